// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue
//
// Instruction-fetch unit with a DEPTH-entry prefetch queue. After a redirect
// (fetch_init) it streams sequential reads to memory, with at most one read
// outstanding. Returned words are queued together with their PC. The head
// entry is presented show-ahead. A redirect flushes the queue. A read that is
// still in flight when the redirect arrives is dropped when it returns.
//
// Ports
//   clk              clock, all state on the rising edge
//   reset_n          asynchronous active-low reset
//   sync_reset       synchronous reset, same end state as reset_n
//   fetch_init       one-cycle redirect to start_addr, flushes the queue
//   start_addr       redirect target, sampled with fetch_init
//   fetch_next       pops the head entry when fetch_valid_out is high
//   fetch_valid_out  head entry valid
//   IR_out / PC_out  head instruction / PC, zero when not valid
//   queue_count      number of occupied entries
//   mem_read_done    one-cycle pulse, mem_data valid
//   mem_data         read return data
//   read_mem_enable  registered one-cycle read request pulse
//   read_mem_addr    registered request address, held until the next request
module fetch_prefetch_queue #(
    parameter int PC_BITWIDTH = 32,
    parameter int XLEN        = 32,
    parameter int DEPTH       = 4,   // power of two, at least 2
    parameter int PC_INC      = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sync_reset,
    input  logic                         fetch_init,
    input  logic [PC_BITWIDTH-1:0]       start_addr,
    input  logic                         fetch_next,
    output logic                         fetch_valid_out,
    output logic [XLEN-1:0]              IR_out,
    output logic [PC_BITWIDTH-1:0]       PC_out,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count,
    input  logic                         mem_read_done,
    input  logic [XLEN-1:0]              mem_data,
    output logic                         read_mem_enable,
    output logic [PC_BITWIDTH-1:0]       read_mem_addr
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0]          DEPTH_C = CW'(DEPTH);
    localparam logic [PC_BITWIDTH-1:0] INC_C   = PC_BITWIDTH'(PC_INC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [PC_BITWIDTH-1:0]  next_pc_q, next_pc_d;
    logic                    discard_q, discard_d;

    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [PC_BITWIDTH-1:0]  pc_mem_q [DEPTH];
    logic [XLEN-1:0]         ir_mem_q [DEPTH];

    // Registered copy of the head entry so no output depends on an input
    // combinationally.
    logic                    head_vld_q, head_vld_d;
    logic [PC_BITWIDTH-1:0]  head_pc_q, head_pc_d;
    logic [XLEN-1:0]         head_ir_q, head_ir_d;

    logic                    req_en_q, req_en_d;
    logic [PC_BITWIDTH-1:0]  req_addr_q, req_addr_d;

    logic                    push, pop, flush, issue, pop_ok;
    logic [PC_BITWIDTH-1:0]  issue_addr;
    logic [CW-1:0]           cnt_after;

    // ------------------------------------------------------------------
    // Control FSM: issue / wait / flush decisions
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        next_pc_d  = next_pc_q;
        discard_d  = discard_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        issue      = 1'b0;
        issue_addr = '0;
        cnt_after  = '0;
        pop_ok     = fetch_next && (count_q != '0);

        unique case (state_q)
            S_IDLE: begin
                if (fetch_init) begin
                    flush      = 1'b1;
                    issue      = 1'b1;
                    issue_addr = start_addr;
                    next_pc_d  = start_addr + INC_C;
                    state_d    = S_WAIT;
                end
            end

            S_ISSUE: begin
                if (fetch_init) begin
                    flush      = 1'b1;
                    issue      = 1'b1;
                    issue_addr = start_addr;
                    next_pc_d  = start_addr + INC_C;
                    state_d    = S_WAIT;
                end else begin
                    pop = pop_ok;
                    // Room is judged on the current count; a pop this cycle
                    // frees space that is used on the following edge.
                    if (count_q < DEPTH_C) begin
                        issue      = 1'b1;
                        issue_addr = next_pc_q;
                        next_pc_d  = next_pc_q + INC_C;
                        state_d    = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (fetch_init) begin
                    flush = 1'b1;
                    if (mem_read_done) begin
                        // The returning word belongs to the old stream: drop
                        // it and start the new stream right away.
                        issue      = 1'b1;
                        issue_addr = start_addr;
                        next_pc_d  = start_addr + INC_C;
                        discard_d  = 1'b0;
                    end else begin
                        // A read is still in flight; the target is issued
                        // from S_ISSUE once the stale return is swallowed.
                        discard_d = 1'b1;
                        next_pc_d = start_addr;
                    end
                end else if (mem_read_done && discard_q) begin
                    discard_d = 1'b0;
                    pop       = pop_ok;
                    state_d   = S_ISSUE;
                end else if (mem_read_done) begin
                    push      = 1'b1;
                    pop       = pop_ok;
                    cnt_after = count_q + CW'(1) - CW'(pop);
                    if (cnt_after < DEPTH_C) begin
                        issue      = 1'b1;
                        issue_addr = next_pc_q;
                        next_pc_d  = next_pc_q + INC_C;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    pop = pop_ok;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (sync_reset) begin
            state_d    = S_IDLE;
            next_pc_d  = '0;
            discard_d  = 1'b0;
            push       = 1'b0;
            pop        = 1'b0;
            flush      = 1'b1;
            issue      = 1'b0;
            issue_addr = '0;
        end
    end

    // ------------------------------------------------------------------
    // Queue pointers, count, next head and request registers
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end

        head_vld_d = (count_d != '0);
        head_pc_d  = '0;
        head_ir_d  = '0;
        if (head_vld_d) begin
            // The new head may be the word being written on this very edge.
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_pc_d = req_addr_q;
                head_ir_d = mem_data;
            end else begin
                head_pc_d = pc_mem_q[rd_ptr_d];
                head_ir_d = ir_mem_q[rd_ptr_d];
            end
        end

        req_en_d   = issue;
        req_addr_d = issue ? issue_addr : req_addr_q;
        if (sync_reset) begin
            req_addr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            next_pc_q  <= '0;
            discard_q  <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            head_vld_q <= 1'b0;
            head_pc_q  <= '0;
            head_ir_q  <= '0;
            req_en_q   <= 1'b0;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            next_pc_q  <= next_pc_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            head_vld_q <= head_vld_d;
            head_pc_q  <= head_pc_d;
            head_ir_q  <= head_ir_d;
            req_en_q   <= req_en_d;
            req_addr_q <= req_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage: {PC, IR}; the PC is the address of the returning read
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i] <= '0;
                ir_mem_q[i] <= '0;
            end
        end else if (sync_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i] <= '0;
                ir_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q] <= req_addr_q;
            ir_mem_q[wr_ptr_q] <= mem_data;
        end
    end

    assign fetch_valid_out = head_vld_q;
    assign IR_out          = head_ir_q;
    assign PC_out          = head_pc_q;
    assign queue_count     = count_q;
    assign read_mem_enable = req_en_q;
    assign read_mem_addr   = req_addr_q;

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Parametrised instruction-fetch unit with a DEPTH-entry prefetch queue. It sits between the scheduler and the memory controller and succeeds the single-slot fetcher. After `fetch_init` it streams sequential reads ahead of the consumer, one outstanding read at a time, and presents the head instruction and its PC as a show-ahead queue. A redirect flushes the queue and discards any in-flight return.

## Interface
- `PC_BITWIDTH`, 32: address width.
- `XLEN`, 32: instruction/data width.
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `PC_INC`, 4: address increment per fetch.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `sync_reset` in 1: synchronous reset; same end state as `reset_n`.
- `fetch_init` in 1: one-cycle redirect; loads `start_addr` and flushes the queue.
- `start_addr` in PC_BITWIDTH: redirect target; sampled with `fetch_init`.
- `fetch_next` in 1: pops the head entry when `fetch_valid_out`=1.
- `fetch_valid_out` out 1: head entry valid (count != 0).
- `IR_out` out XLEN: head instruction; 0 when not valid.
- `PC_out` out PC_BITWIDTH: head PC; 0 when not valid.
- `queue_count` out clog2(DEPTH+1): occupied entries.
- `mem_read_done` in 1: one-cycle pulse; `mem_data` valid.
- `mem_data` in XLEN: read return data.
- `read_mem_enable` out 1: registered one-cycle read request pulse.
- `read_mem_addr` out PC_BITWIDTH: registered request address; held until next request.

## Operation
- Storage: circular buffer of {PC, IR} entries, with read pointer, write pointer and count. Pointers wrap modulo DEPTH.
- Registers: `next_pc`, `discard` flag, and FSM state S_IDLE / S_ISSUE / S_WAIT.
- All outputs are driven from registers. There is no combinational path from any input to any output.
- S_IDLE: the unit ignores `mem_read_done` and `fetch_next`. On `fetch_init`: issue at `start_addr`, set `next_pc` = `start_addr`+PC_INC, and go to S_WAIT.
- S_ISSUE: if count < DEPTH, issue at `next_pc`, advance `next_pc` and go to S_WAIT; otherwise stay.
- S_WAIT, `mem_read_done`, `discard`=0:
  - Push {`read_mem_addr`, `mem_data`}.
  - If (count + 1 − pop) < DEPTH, issue the next read on the same edge and stay in S_WAIT; otherwise go to S_ISSUE.
- S_WAIT, `mem_read_done`, `discard`=1: drop the data, clear `discard`, go to S_ISSUE.
- Issue: on the next cycle `read_mem_enable`=1 and `read_mem_addr` = issued address.
- Redirect (`fetch_init`) in S_ISSUE or S_WAIT:
  - Queue empties; pointers and count go to 0; a same-cycle `fetch_next` is ignored.
  - In S_ISSUE: issue at `start_addr` immediately, as in S_IDLE.
  - In S_WAIT with no `mem_read_done` the same cycle: set `discard`, set `next_pc` = `start_addr`, stay in S_WAIT. The redirect target is issued after the stale return.
  - In S_WAIT with `mem_read_done` the same cycle: drop the data and issue at `start_addr` immediately.
- Priority: `sync_reset` > `fetch_init` > push/pop.
- Pop: `fetch_next` with count=0 is ignored.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Arithmetic: `next_pc` wraps modulo 2^PC_BITWIDTH (e.g. 0xFFFF_FFFC + 4 = 0).
- `sync_reset` / `reset_n`:
  - State goes to S_IDLE; queue empties; `discard`=0.
  - All outputs and registers reset to 0.
  - The memory controller shares `sync_reset`, so no stale `mem_read_done` follows it.

## Timing
- At most one read outstanding at any time.
- Redirect: `fetch_init` sampled at edge T gives `read_mem_enable` high in cycle T+1 (no redirect-while-waiting case).
- Push: `mem_read_done` sampled at edge E gives `fetch_valid_out`=1 (when previously empty) and the next `read_mem_enable` in cycle E+1.
- Pop: `fetch_next` at edge P makes the next entry visible in cycle P+1.
- Queue full: no request is issued until a pop. The request then follows one cycle after the pop edge, via S_ISSUE.
- `queue_count` never exceeds DEPTH.

## Test plan
- **Redirect and fill:** reset; `fetch_init`, `start_addr`=0x100; memory latency 1, data = address ^ 0xA5A5_0000; no pops.
  - Required: reads at 0x100, 0x104, 0x108, 0x10C, then none.
  - Required: `queue_count`=4; head PC=0x100, IR=0xA5A5_0100.
- **Streaming:** `fetch_next` held high after the first valid.
  - Required: PC_out sequence 0x100, 0x104, … with no skipped or duplicated entries.
  - Required: count stays at or below DEPTH.
- **Redirect mid-read:** `fetch_init` to 0x200 while the read of 0x108 is outstanding.
  - Required: the 0x108 data never appears on the outputs.
  - Required: the next request is 0x200, issued the cycle after the stale `mem_read_done`.
  - Required: `queue_count`=0 on the cycle after the redirect.
- **Redirect on the return edge:** `fetch_init` coincident with `mem_read_done`.
  - Required: data dropped; `read_mem_enable` with `start_addr` on the next cycle.
- **Empty-pop and address wrap:** `fetch_next` while empty gives no change. `start_addr`=0xFFFF_FFF8 gives reads at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
- **Reset mid-operation:** `sync_reset` with the queue holding 3 entries and a read outstanding.
  - Required: all outputs 0 and S_IDLE next cycle.
  - Required: a subsequent `fetch_init` behaves as from power-up.
